// File: rtl/sel_mem_pkg.sv
// Shared constants and scan FSM encoding for the selectable memory array.
package sel_mem_pkg;

    localparam int SEL_MEM_WIDTH  = 4;
    localparam int SEL_MEM_NUM_CH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/sel_mem_scan.sv
// Scan FSM: streams every channel out over a valid/ready handshake.
// The top supplies the (write-forwarded) data of the channel named on fetch_ch.
module sel_mem_scan
    import sel_mem_pkg::*;
#(
    parameter int WIDTH  = SEL_MEM_WIDTH,
    parameter int NUM_CH = SEL_MEM_NUM_CH,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             scan_start,
    input  logic             out_ready,
    input  logic [WIDTH-1:0] fetch_data,
    output logic [CH_W-1:0]  fetch_ch,
    output logic             scan_busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CH_W-1:0]  out_ch,
    output logic             scan_done
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    scan_state_e      state_r, state_n;
    logic             out_valid_r, out_valid_n;
    logic [WIDTH-1:0] out_data_r, out_data_n;
    logic [CH_W-1:0]  out_ch_r, out_ch_n;
    logic             scan_done_r, scan_done_n;
    logic             scan_busy_r, scan_busy_n;
    logic             hs_s;
    logic [CH_W-1:0]  fetch_ch_s;

    assign hs_s = out_valid_r & out_ready;

    // Channel to pre-fetch: channel 0 when starting, otherwise the next one.
    always_comb begin
        fetch_ch_s = {CH_W{1'b0}};
        if (state_r == ST_IDLE) begin
            fetch_ch_s = {CH_W{1'b0}};
        end else begin
            fetch_ch_s = out_ch_r + CH_W'(1);
        end
    end

    // Next-state and next-output decode; clr aborts any scan without a done pulse.
    always_comb begin
        state_n     = state_r;
        out_valid_n = out_valid_r;
        out_data_n  = out_data_r;
        out_ch_n    = out_ch_r;
        scan_done_n = 1'b0;
        scan_busy_n = scan_busy_r;
        case (state_r)
            ST_IDLE: begin
                if (clr) begin
                    state_n = ST_IDLE;
                end else if (scan_start) begin
                    state_n     = ST_SCAN;
                    out_valid_n = 1'b1;
                    out_ch_n    = {CH_W{1'b0}};
                    out_data_n  = fetch_data;
                    scan_busy_n = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (clr) begin
                    state_n     = ST_IDLE;
                    out_valid_n = 1'b0;
                    out_data_n  = {WIDTH{1'b0}};
                    out_ch_n    = {CH_W{1'b0}};
                    scan_busy_n = 1'b0;
                end else if (hs_s) begin
                    if (out_ch_r == LAST_CH) begin
                        state_n     = ST_DONE;
                        out_valid_n = 1'b0;
                        scan_done_n = 1'b1;
                    end else begin
                        out_ch_n   = out_ch_r + CH_W'(1);
                        out_data_n = fetch_data;
                    end
                end else begin
                    state_n = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (clr) begin
                    out_data_n = {WIDTH{1'b0}};
                    out_ch_n   = {CH_W{1'b0}};
                end else begin
                    out_data_n = out_data_r;
                end
                state_n     = ST_IDLE;
                out_valid_n = 1'b0;
                scan_busy_n = 1'b0;
            end
            default: begin
                state_n     = ST_IDLE;
                out_valid_n = 1'b0;
                scan_busy_n = 1'b0;
            end
        endcase
    end

    // State and handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_ch_r    <= {CH_W{1'b0}};
            scan_done_r <= 1'b0;
            scan_busy_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            out_valid_r <= out_valid_n;
            out_data_r  <= out_data_n;
            out_ch_r    <= out_ch_n;
            scan_done_r <= scan_done_n;
            scan_busy_r <= scan_busy_n;
        end
    end

    assign fetch_ch  = fetch_ch_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign scan_done = scan_done_r;
    assign scan_busy = scan_busy_r;

endmodule

// File: rtl/sel_mem_array.sv
// Multi-channel register array with a registered read port and a scan streamer.
// Same-edge writes are forwarded to both the read port and the scan fetch.
module sel_mem_array
    import sel_mem_pkg::*;
#(
    parameter int WIDTH  = SEL_MEM_WIDTH,
    parameter int NUM_CH = SEL_MEM_NUM_CH,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_sel,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [CH_W-1:0]   rd_sel,
    output logic [WIDTH-1:0]  data_out,
    output logic [NUM_CH-1:0] ch_valid,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              scan_done
);

    localparam logic [CH_W:0] NUM_CH_C = (CH_W + 1)'(NUM_CH);

    logic [WIDTH-1:0]  mem_r [NUM_CH];
    logic [NUM_CH-1:0] ch_valid_r;
    logic [WIDTH-1:0]  data_out_r;
    logic              wr_hit_s;
    logic [WIDTH-1:0]  rd_data_s;
    logic [WIDTH-1:0]  fetch_data_s;
    logic [CH_W-1:0]   fetch_ch_s;

    // A write takes effect only when not clearing and the channel exists.
    always_comb begin
        wr_hit_s = 1'b0;
        if (wr_en && !clr && ({1'b0, wr_sel} < NUM_CH_C)) begin
            wr_hit_s = 1'b1;
        end else begin
            wr_hit_s = 1'b0;
        end
    end

    // Read-port mux with write-through; out-of-range selects read as zero.
    always_comb begin
        rd_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == CH_W'(i)) begin
                if (wr_hit_s && (wr_sel == rd_sel)) begin
                    rd_data_s = data_in;
                end else begin
                    rd_data_s = mem_r[i];
                end
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Scan fetch mux, forwarded the same way as the read port.
    always_comb begin
        fetch_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (fetch_ch_s == CH_W'(i)) begin
                if (wr_hit_s && (wr_sel == fetch_ch_s)) begin
                    fetch_data_s = data_in;
                end else begin
                    fetch_data_s = mem_r[i];
                end
            end else begin
                fetch_data_s = fetch_data_s;
            end
        end
    end

    // Channel storage and written flags; clr wipes everything at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            ch_valid_r <= {NUM_CH{1'b0}};
        end else if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            ch_valid_r <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit_s && (wr_sel == CH_W'(i))) begin
                    mem_r[i]      <= data_in;
                    ch_valid_r[i] <= 1'b1;
                end
            end
        end
    end

    // Registered read data, zeroed together with the channels on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            data_out_r <= {WIDTH{1'b0}};
        end else begin
            data_out_r <= rd_data_s;
        end
    end

    sel_mem_scan #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .scan_start (scan_start),
        .out_ready  (out_ready),
        .fetch_data (fetch_data_s),
        .fetch_ch   (fetch_ch_s),
        .scan_busy  (scan_busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .scan_done  (scan_done)
    );

    assign data_out = data_out_r;
    assign ch_valid = ch_valid_r;

endmodule
